qspi_stream_tx: RTL and testbench

//  Host-side QSPI transmitter sitting directly upstream of the Parallelizer.
//  On start it pulses prog, then sends the key as one burst of nibbles, MSB first.
//  It then streams a byte FIFO as high/low nibble pairs, honouring qspi_ready, until the last-flagged byte.
//  It replaces the bench-driven key/data sequencing with synthesizable logic.

---
 rtl/qspi_stream_tx.sv | 182 ++++++++++++++++++
 tb/tb_qspi_stream_tx.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_stream_tx.sv
// Host-side QSPI transmitter: program strobe, key burst (MSB nibble first), then a byte
// FIFO streamed as high/low nibble pairs under qspi_ready flow control.
module qspi_stream_tx #(
    parameter int KEY_WIDTH  = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic [7:0]           byte_data,
    input  logic                 byte_last,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 prog,
    output logic                 qspi_sending,
    output logic [3:0]           qspi_data,
    input  logic                 qspi_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int NIB_N = KEY_WIDTH / 4;
    localparam int NIB_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PROG,
        S_WAIT_KEY,
        S_KEY_SETUP,
        S_KEY,
        S_KEY_END,
        S_WAIT_DATA,
        S_DATA_SETUP,
        S_DATA_HI,
        S_DATA_LO,
        S_DATA_GAP,
        S_DONE
    } state_t;

    state_t               state, state_next;
    logic [KEY_WIDTH-1:0] key_reg;
    logic [KEY_WIDTH-1:0] key_shift;
    logic [NIB_W-1:0]     nib_cnt, nib_cnt_next;

    logic [8:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_ptr_inc;
    logic [CNT_W-1:0]     count;
    logic                 push, pop;
    logic [8:0]           head;
    logic [7:0]           head_byte_next;

    logic                 prog_next, sending_next, busy_next, done_next;
    logic [3:0]           data_next;

    assign byte_ready = (count != CNT_W'(FIFO_DEPTH));
    assign push       = byte_valid && byte_ready;
    assign head       = mem[rd_ptr];
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        nib_cnt_next = nib_cnt;
        pop          = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next   = S_PROG;
                    nib_cnt_next = '0;
                end
            end
            S_PROG:       state_next = S_WAIT_KEY;
            S_WAIT_KEY:   if (qspi_ready) state_next = S_KEY_SETUP;
            S_KEY_SETUP:  state_next = S_KEY;
            S_KEY: begin
                if (nib_cnt == NIB_W'(NIB_N - 1)) state_next = S_KEY_END;
                else nib_cnt_next = nib_cnt + NIB_W'(1);
            end
            S_KEY_END:    state_next = S_WAIT_DATA;
            S_WAIT_DATA:  if (qspi_ready && count != '0) state_next = S_DATA_SETUP;
            S_DATA_SETUP: state_next = S_DATA_HI;
            S_DATA_HI:    if (qspi_ready) state_next = S_DATA_LO;
            S_DATA_LO: begin
                if (qspi_ready) begin
                    pop = 1'b1;
                    if (head[8])                           state_next = S_DONE;
                    else if (count > CNT_W'(1) || push)    state_next = S_DATA_HI;
                    else                                   state_next = S_DATA_GAP;
                end
            end
            S_DATA_GAP:   state_next = S_WAIT_DATA;
            S_DONE:       state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    // Head seen after this edge; a byte landing in the slot just behind the popped one is forwarded.
    always_comb begin
        head_byte_next = head[7:0];
        if (pop) begin
            if (push && wr_ptr == rd_ptr_inc) head_byte_next = byte_data;
            else                              head_byte_next = mem[rd_ptr_inc][7:0];
        end
    end

    // Outputs are decoded from the next state and registered, so they change only on clock edges.
    always_comb begin
        key_shift    = key_reg << {nib_cnt_next, 2'b00};
        prog_next    = 1'b0;
        sending_next = 1'b0;
        data_next    = 4'h0;
        done_next    = 1'b0;
        busy_next    = (state_next != S_IDLE);
        case (state_next)
            S_PROG:       prog_next = 1'b1;
            S_KEY_SETUP,
            S_DATA_SETUP: sending_next = 1'b1;
            S_KEY: begin
                sending_next = 1'b1;
                data_next    = key_shift[KEY_WIDTH-1 -: 4];
            end
            S_DATA_HI: begin
                sending_next = 1'b1;
                data_next    = head_byte_next[7:4];
            end
            S_DATA_LO: begin
                sending_next = 1'b1;
                data_next    = head_byte_next[3:0];
            end
            S_DONE:       done_next = 1'b1;
            default:      ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            key_reg      <= '0;
            nib_cnt      <= '0;
            prog         <= 1'b0;
            qspi_sending <= 1'b0;
            qspi_data    <= 4'h0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            nib_cnt      <= nib_cnt_next;
            if (state == S_IDLE && start) key_reg <= key;
            prog         <= prog_next;
            qspi_sending <= sending_next;
            qspi_data    <= data_next;
            busy         <= busy_next;
            done         <= done_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {byte_last, byte_data};
    end

endmodule

// File: tb/tb_qspi_stream_tx.sv
// Directed bench for qspi_stream_tx: per-cycle expected output plans for key bursts,
// data streaming, flow-control stalls, underrun, FIFO full and asynchronous reset.
module tb_qspi_stream_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] key = '0;
    logic [7:0]  byte_data = '0;
    logic        byte_last = 1'b0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        prog;
    logic        qspi_sending;
    logic [3:0]  qspi_data;
    logic        qspi_ready = 1'b1;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       start;
        logic       rdy;
        logic       push;
        logic [8:0] pbyte;
        logic [7:0] exp;   // {prog, sending, data[3:0], done, busy}
    } step_t;

    step_t       plan[$];
    logic [31:0] run_key;
    logic [7:0]  obs;

    assign obs = {prog, qspi_sending, qspi_data, done, busy};

    qspi_stream_tx #(.KEY_WIDTH(32), .FIFO_DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .key          (key),
        .byte_data    (byte_data),
        .byte_last    (byte_last),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .prog         (prog),
        .qspi_sending (qspi_sending),
        .qspi_data    (qspi_data),
        .qspi_ready   (qspi_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] o(input logic p, input logic s, input logic [3:0] d,
                                     input logic dn, input logic b);
        return {p, s, d, dn, b};
    endfunction

    task automatic add_r(input logic [7:0] e, input logic rdy);
        step_t st;
        st = '0;
        st.rdy = rdy;
        st.exp = e;
        plan.push_back(st);
    endtask

    task automatic add(input logic [7:0] e);
        add_r(e, 1'b1);
    endtask

    // Steps 0..12: start issued at step 0, PROG, WAIT_KEY, KEY_SETUP, 8 nibbles, KEY_END.
    task automatic build_prefix(input logic [31:0] k);
        step_t st;
        plan.delete();
        run_key = k;
        st = '0;
        st.start = 1'b1;
        st.rdy = 1'b1;
        plan.push_back(st);
        add(o(1, 0, 4'h0, 0, 1));
        add(o(0, 0, 4'h0, 0, 1));
        add(o(0, 1, 4'h0, 0, 1));
        for (int i = 0; i < 8; i++) add(o(0, 1, k[31-4*i -: 4], 0, 1));
        add(o(0, 0, 4'h0, 0, 1));
    endtask

    task automatic drive_step(input int k);
        start      = plan[k].start;
        qspi_ready = plan[k].rdy;
        byte_valid = plan[k].push;
        {byte_last, byte_data} = plan[k].pbyte;
        key = (k == 0) ? run_key : ~run_key;
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        byte_valid = 1'b0;
        qspi_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic push_byte(input logic [8:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        {byte_last, byte_data} = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", obs, 8'h00);
        end
        n_checks++;
        if (byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_byte_ready: got %b want 1", byte_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b want %b", obs, 8'h00);
        end
    endtask

    task automatic test_key_burst();
        do_reset();
        build_prefix(32'hB435_2B93);
        add(o(0, 0, 4'h0, 0, 1));                    // WAIT_DATA, FIFO empty
        for (int k = 0; k < plan.size(); k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== plan[k].exp) begin
                n_fail++;
                $display("FAIL key_burst step %0d: got %b want %b", k, obs, plan[k].exp);
            end
            drive_step(k);
        end
        idle_inputs();
    endtask

    task automatic test_preload_data();
        do_reset();
        push_byte(9'h048);
        push_byte(9'h169);
        build_prefix(32'hC0DE_1234);
        add(o(0, 0, 4'h0, 0, 1));                    // WAIT_DATA
        add(o(0, 1, 4'h0, 0, 1));                    // DATA_SETUP
        add(o(0, 1, 4'h4, 0, 1));
        add(o(0, 1, 4'h8, 0, 1));
        add(o(0, 1, 4'h6, 0, 1));
        add(o(0, 1, 4'h9, 0, 1));
        add(o(0, 0, 4'h0, 1, 1));                    // DONE
        add(o(0, 0, 4'h0, 0, 0));                    // IDLE
        for (int k = 0; k < plan.size(); k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== plan[k].exp) begin
                n_fail++;
                $display("FAIL preload_data step %0d: got %b want %b", k, obs, plan[k].exp);
            end
            drive_step(k);
        end
        idle_inputs();
    endtask

    task automatic test_ready_stall();
        do_reset();
        push_byte(9'h048);
        push_byte(9'h169);
        build_prefix(32'h8765_4321);
        add(o(0, 0, 4'h0, 0, 1));                    // WAIT_DATA
        add(o(0, 1, 4'h0, 0, 1));                    // DATA_SETUP
        add(o(0, 1, 4'h4, 0, 1));
        add_r(o(0, 1, 4'h8, 0, 1), 1'b0);            // low nibble held while not ready
        add_r(o(0, 1, 4'h8, 0, 1), 1'b0);
        add_r(o(0, 1, 4'h8, 0, 1), 1'b0);
        add(o(0, 1, 4'h8, 0, 1));
        add(o(0, 1, 4'h6, 0, 1));
        add(o(0, 1, 4'h9, 0, 1));
        add(o(0, 0, 4'h0, 1, 1));
        add(o(0, 0, 4'h0, 0, 0));
        for (int k = 0; k < plan.size(); k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== plan[k].exp) begin
                n_fail++;
                $display("FAIL ready_stall step %0d: got %b want %b", k, obs, plan[k].exp);
            end
            drive_step(k);
        end
        idle_inputs();
    endtask

    task automatic test_underrun();
        do_reset();
        build_prefix(32'h1234_5678);
        plan[11].push  = 1'b1;
        plan[11].pbyte = 9'h041;
        add(o(0, 0, 4'h0, 0, 1));                    // 13 WAIT_DATA
        add(o(0, 1, 4'h0, 0, 1));                    // 14 DATA_SETUP
        add(o(0, 1, 4'h4, 0, 1));
        add(o(0, 1, 4'h1, 0, 1));
        add(o(0, 0, 4'h0, 0, 1));                    // 17 DATA_GAP
        for (int i = 0; i < 5; i++) add(o(0, 0, 4'h0, 0, 1));
        plan[21].push  = 1'b1;
        plan[21].pbyte = 9'h142;
        add(o(0, 1, 4'h0, 0, 1));                    // 23 new setup cycle
        add(o(0, 1, 4'h4, 0, 1));
        add(o(0, 1, 4'h2, 0, 1));
        add(o(0, 0, 4'h0, 1, 1));
        add(o(0, 0, 4'h0, 0, 0));
        add(o(0, 0, 4'h0, 0, 0));
        for (int k = 0; k < plan.size(); k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== plan[k].exp) begin
                n_fail++;
                $display("FAIL underrun step %0d: got %b want %b", k, obs, plan[k].exp);
            end
            drive_step(k);
        end
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if (byte_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fifo_ready before push %0d: got %b want 1", i, byte_ready);
            end
            byte_valid = 1'b1;
            byte_last  = (i == 15);
            byte_data  = {4'(i), 4'(15 - i)};
        end
        @(negedge clk);
        n_checks++;
        if (byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_full_ready: got %b want 0", byte_ready);
        end
        byte_last = 1'b0;
        byte_data = 8'hEE;                           // 17th byte offered while full
        @(negedge clk);
        byte_valid = 1'b0;
        n_checks++;
        if (byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_still_full: got %b want 0", byte_ready);
        end
        build_prefix(32'h5A0F_C396);
        add(o(0, 0, 4'h0, 0, 1));
        add(o(0, 1, 4'h0, 0, 1));
        for (int i = 0; i < 16; i++) begin
            add(o(0, 1, 4'(i), 0, 1));
            add(o(0, 1, 4'(15 - i), 0, 1));
        end
        add(o(0, 0, 4'h0, 1, 1));
        add(o(0, 0, 4'h0, 0, 0));
        for (int k = 0; k < plan.size(); k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== plan[k].exp) begin
                n_fail++;
                $display("FAIL fifo_full_stream step %0d: got %b want %b", k, obs, plan[k].exp);
            end
            drive_step(k);
        end
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fifo_drained_ready: got %b want 1", byte_ready);
        end
    endtask

    task automatic test_reset_mid_key();
        do_reset();
        push_byte(9'h1A5);
        build_prefix(32'hB435_2B93);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== plan[k].exp) begin
                n_fail++;
                $display("FAIL mid_key step %0d: got %b want %b", k, obs, plan[k].exp);
            end
            drive_step(k);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %b want %b", obs, 8'h00);
        end
        n_checks++;
        if (byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_ready: got %b want 1", byte_ready);
        end
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        build_prefix(32'h0F1E_2D3C);
        for (int i = 0; i < 3; i++) add(o(0, 0, 4'h0, 0, 1));  // FIFO flushed: stays in WAIT_DATA
        for (int k = 0; k < plan.size(); k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== plan[k].exp) begin
                n_fail++;
                $display("FAIL replay step %0d: got %b want %b", k, obs, plan[k].exp);
            end
            drive_step(k);
        end
        idle_inputs();
        do_reset();
    endtask

    initial begin
        test_reset();
        test_key_burst();
        test_preload_data();
        test_ready_stall();
        test_underrun();
        test_fifo_full();
        test_reset_mid_key();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
